seg7_scan_capture: RTL and testbench
====================================

# seg7_scan_capture

Receive-side companion to the multiplexed 7-segment display driver. It samples the scanned segment and anode lines and filters out scan transitions. It decodes each stable segment pattern back to a hex nibble and reassembles the four digits into one 16-bit word. The word is offered on a valid/ready interface to a checker or logger.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (min 2).
- TIMEOUT_CYCLES, 65536: cycles without an accepted digit before `stall` asserts.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- seg  in  7  segments {g,f,e,d,c,b,a}, active-low.
- an  in  4  digit anodes, active-low one-hot; an[0] = least significant nibble.
- frame_data  out  16  captured digits {d3,d2,d1,d0}.
- frame_err  out  1  frame contained at least one undecodable pattern; qualified by frame_valid.
- frame_valid  out  1  frame_data/frame_err valid; held until accepted.
- frame_ready  in  1  consumer accepts frame when high with frame_valid.
- overrun  out  1  one-cycle pulse: completed frame dropped because the output slot was full.
- stall  out  1  no digit accepted for TIMEOUT_CYCLES.

## Operation
- Reset values: all outputs 0. `seen` = 4'b0000. Error bits 0. Counters 0. Input sample registers reset to an = 4'hF, seg = 7'h7F (blank).
- Stability filter:
  - Counter increments while sampled {an,seg} equals the previous sample. Any change clears it to 0.
  - On reaching STABLE_CYCLES-1, exactly one accept event fires.
  - No further accepts until the inputs change.
- On accept, if `an` is one-hot low:
  - Digit k is written with the decoded nibble, and seen[k] is set.
  - An undecodable pattern writes nibble 0 and sets err[k].
  - A repeated digit overwrites the earlier value (latest wins).
- On accept, if `an` is all-high (blanking) or has more than one bit low: ignored entirely, and the stall counter does not clear.
- Decode table (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- FSM:
  - ST_IDLE (seen==0) -> ST_COLLECT on first valid accept.
  - ST_COLLECT -> ST_EMIT when seen==4'b1111.
  - ST_EMIT -> ST_IDLE after one cycle.
- ST_EMIT behaviour:
  - If the slot is empty (!frame_valid) or draining this cycle (frame_valid && frame_ready): load frame_data, set frame_err = |err, set frame_valid.
  - Otherwise pulse overrun and keep the held frame unchanged.
  - Either way, clear seen and err.
- Handshake:
  - frame_valid falls on the edge where frame_valid && frame_ready, unless a new frame loads on that same edge.
  - frame_data is stable while valid.
- Stall:
  - Counter counts cycles since the last valid accept and saturates at TIMEOUT_CYCLES; stall = saturated.
  - On the rising edge of stall, a partial frame (seen, err) is discarded and the FSM returns to ST_IDLE.
  - Next valid accept clears stall.
- Reset mid-operation: asynchronous return to reset values. Partial and held frames are lost.

## Timing
- Input latency L = 2 with the synchronizer compiled in, 0 without.
- Pin change -> accept edge: L + STABLE_CYCLES cycles.
- Accept of fourth digit -> ST_EMIT one edge later -> frame_valid high the following edge.
- overrun is high for exactly one cycle, at the ST_EMIT edge.
- Throughput: one frame per complete scan; consumer may hold frame_ready low indefinitely.

## Configuration
- SEG7_CAP_SYNC_EN defined: 2-flop synchronizer on seg and an (asynchronous display pins), L = 2.
- SEG7_CAP_SYNC_EN undefined: inputs sampled directly (same-clock driver, simulation), L = 0. Otherwise identical.

## Structure
- Package seg7_pkg:
  - typedef seg_t (logic [6:0]).
  - SEG_0..SEG_F pattern constants.
  - FSM state enum.
  - SEG_BLANK = 7'h7F.
- Sub-module seg7_pattern_decode: combinational seg_t -> {nibble, known}; reusable by other benches.

## Test plan
- Scan 0x1234 (an 1110/1101/1011/0111, 50 cycles each) -> frame_valid with frame_data = 16'h1234, frame_err = 0.
- Glitch: seg changes for 2 cycles mid-digit (STABLE_CYCLES = 4) -> glitch not captured; frame unchanged.
- Digit 2 pattern 7'b1010101 in scan 0x5678 -> frame_data = 16'h5078, frame_err = 1.
- frame_ready held 0 across two full scans -> first frame held, overrun pulses once, frame_data unchanged.
- Scan digits 0 and 1 only, then an = 4'hF for TIMEOUT_CYCLES -> stall = 1, no frame. Next full scan 0x90AF -> stall = 0, frame 16'h90AF.
- Assert reset during ST_COLLECT with frame_valid = 1 -> all outputs 0 immediately. Next full scan 0x9BCD -> frame 16'h9BCD.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan capture block.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [1:0] state_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'h7F;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StCollect = 2'd1;
  localparam state_t StEmit    = 2'd2;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Frame output channel: valid/ready handshake carrying one captured 16-bit word.
interface seg7_scan_capture_if;
  logic [15:0] frame_data;
  logic        frame_err;
  logic        frame_valid;
  logic        frame_ready;

  modport master (
    output frame_data,
    output frame_err,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_err,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to hex-nibble decoder; known_o low for undecodable patterns.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] nibble_o,
  output logic       known_o
);

  // Table lookup; anything off-table decodes to 0 with known_o cleared.
  always_comb begin
    nibble_o = 4'h0;
    known_o  = 1'b1;
    case (seg_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: known_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a scanned 4-digit 7-segment display back into 16-bit frames.
// Define SEG7_CAP_SYNC_EN to add a 2-flop synchronizer on seg/an (asynchronous pins).
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned StableCycles  = 4,
  parameter int unsigned TimeoutCycles = 65536
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  seg_t                       seg_i,
  input  logic [3:0]                 an_i,
  seg7_scan_capture_if.master        frame_o,
  output logic                       overrun_o,
  output logic                       stall_o
);

  localparam int unsigned CntW = $clog2(StableCycles + 1);
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(StableCycles - 1);
  localparam logic [CntW-1:0] CntAccept = CntW'(StableCycles - 2);
  localparam logic [TmoW-1:0] TmoMax    = TmoW'(TimeoutCycles);

  logic [10:0] cur;

`ifdef SEG7_CAP_SYNC_EN
  logic [10:0] sync1_q, sync2_q;

  // Two-flop synchronizer; resets to blank so no spurious digit is seen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= {4'hF, SEG_BLANK};
      sync2_q <= {4'hF, SEG_BLANK};
    end else begin
      sync1_q <= {an_i, seg_i};
      sync2_q <= sync1_q;
    end
  end
  assign cur = sync2_q;
`else
  assign cur = {an_i, seg_i};
`endif

  logic [10:0]      prev_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  state_t           state_q, state_d;
  logic [3:0][3:0]  digits_q, digits_d;
  logic [3:0]       seen_q, seen_d, err_q, err_d;
  logic [15:0]      data_q, data_d;
  logic             ferr_q, ferr_d, fv_q, fv_d, ovr_q, ovr_d;

  logic       same, accept, an_ok, vaccept, known, stall_rise;
  logic [3:0] an_inv, nibble;
  logic [1:0] idx;

  seg7_pattern_decode u_decode (
    .seg_i    (cur[6:0]),
    .nibble_o (nibble),
    .known_o  (known)
  );

  // Accept fires once when the sample has been steady for StableCycles samples.
  always_comb begin
    same    = (cur == prev_q);
    accept  = same && (cnt_q == CntAccept);
    cnt_d   = !same ? '0 : (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    an_inv  = ~cur[10:7];
    an_ok   = (an_inv != 4'h0) && ((an_inv & (an_inv - 4'd1)) == 4'h0);
    vaccept = accept && an_ok;
    case (an_inv)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Digit assembly, frame FSM, output slot and stall timer.
  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    err_d    = err_q;
    digits_d = digits_q;
    data_d   = data_q;
    ferr_d   = ferr_q;
    fv_d     = fv_q;
    ovr_d    = 1'b0;

    if (vaccept)              tmo_d = '0;
    else if (tmo_q != TmoMax) tmo_d = tmo_q + 1'b1;
    else                      tmo_d = tmo_q;
    stall_rise = (tmo_d == TmoMax) && (tmo_q != TmoMax);

    if (fv_q && frame_o.frame_ready) fv_d = 1'b0;

    case (state_q)
      StIdle:    if (vaccept) state_d = StCollect;
      StCollect: if (seen_q == 4'hF) state_d = StEmit;
      StEmit: begin
        state_d = vaccept ? StCollect : StIdle;
        seen_d  = '0;
        err_d   = '0;
        // A slot draining on this same edge counts as free.
        if (!fv_q || frame_o.frame_ready) begin
          data_d = digits_q;
          ferr_d = |err_q;
          fv_d   = 1'b1;
        end else begin
          ovr_d  = 1'b1;
        end
      end
      default:   state_d = StIdle;
    endcase

    if (vaccept) begin
      digits_d[idx] = known ? nibble : 4'h0;
      seen_d[idx]   = 1'b1;
      err_d[idx]    = !known;
    end

    if (stall_rise) begin
      seen_d  = '0;
      err_d   = '0;
      state_d = StIdle;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q   <= {4'hF, SEG_BLANK};
      cnt_q    <= '0;
      tmo_q    <= '0;
      state_q  <= StIdle;
      digits_q <= '0;
      seen_q   <= '0;
      err_q    <= '0;
      data_q   <= '0;
      ferr_q   <= 1'b0;
      fv_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      prev_q   <= cur;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      data_q   <= data_d;
      ferr_q   <= ferr_d;
      fv_q     <= fv_d;
      ovr_q    <= ovr_d;
    end
  end

  assign frame_o.frame_data  = data_q;
  assign frame_o.frame_err   = ferr_q;
  assign frame_o.frame_valid = fv_q;
  assign overrun_o           = ovr_q;
  assign stall_o             = (tmo_q == TmoMax);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (same-clock inputs, shortened timeout).
module tb_seg7_scan_capture;

  localparam int unsigned Tmo = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an = 4'hF;
  logic       overrun, stall;
  int         total = 0;
  int         passed = 0;
  int         ovr_cnt = 0;

  seg7_scan_capture_if fif ();

  seg7_scan_capture #(
    .StableCycles  (4),
    .TimeoutCycles (Tmo)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .seg_i     (seg),
    .an_i      (an),
    .frame_o   (fif),
    .overrun_o (overrun),
    .stall_o   (stall)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun) ovr_cnt++;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
      4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
      4'h8: enc = 7'h00; 4'h9: enc = 7'h10; 4'hA: enc = 7'h08; 4'hB: enc = 7'h03;
      4'hC: enc = 7'h46; 4'hD: enc = 7'h21; 4'hE: enc = 7'h06; default: enc = 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] pats_of(input logic [15:0] w);
    logic [27:0] p;
    for (int i = 0; i < 4; i++) p[7*i +: 7] = enc(w[4*i +: 4]);
    return p;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scan ndig digits (digit 0 first), 50 cycles each; optional 2-cycle glitch on one digit.
  task automatic scan_pats(input logic [27:0] p, input int ndig, input int glitch_dig);
    for (int i = 0; i < ndig; i++) begin
      an  = ~(4'b0001 << i);
      seg = p[7*i +: 7];
      if (i == glitch_dig) begin
        cycles(20);
        seg = 7'h00;
        cycles(2);
        seg = p[7*i +: 7];
        cycles(28);
      end else begin
        cycles(50);
      end
    end
    an  = 4'hF;
    seg = 7'h7F;
  endtask

  task automatic pop();
    fif.frame_ready = 1'b1;
    cycles(1);
    fif.frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    cycles(3);
    @(negedge clk);
    total++; if (fif.frame_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fif.frame_valid); else passed++;
    total++; if (fif.frame_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", fif.frame_data); else passed++;
    total++; if (fif.frame_err !== 1'b0) $display("FAIL reset_err: got %b want 0", fif.frame_err); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_basic();
    scan_pats(pats_of(16'h1234), 4, -1);
    cycles(10);
    @(negedge clk);
    total++; if (fif.frame_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", fif.frame_valid); else passed++;
    total++; if (fif.frame_data !== 16'h1234) $display("FAIL basic_data: got %h want 1234", fif.frame_data); else passed++;
    total++; if (fif.frame_err !== 1'b0) $display("FAIL basic_err: got %b want 0", fif.frame_err); else passed++;
    cycles(1);
    pop();
    @(negedge clk);
    total++; if (fif.frame_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", fif.frame_valid); else passed++;
    cycles(1);
  endtask

  task automatic test_glitch();
    scan_pats(pats_of(16'hABCD), 4, 1);
    cycles(10);
    @(negedge clk);
    total++; if (fif.frame_valid !== 1'b1) $display("FAIL glitch_valid: got %b want 1", fif.frame_valid); else passed++;
    total++; if (fif.frame_data !== 16'hABCD) $display("FAIL glitch_data: got %h want abcd", fif.frame_data); else passed++;
    total++; if (fif.frame_err !== 1'b0) $display("FAIL glitch_err: got %b want 0", fif.frame_err); else passed++;
    cycles(1);
    pop();
  endtask

  task automatic test_bad_pattern();
    logic [27:0] p;
    p = pats_of(16'h5678);
    p[14 +: 7] = 7'b1010101;
    scan_pats(p, 4, -1);
    cycles(10);
    @(negedge clk);
    total++; if (fif.frame_valid !== 1'b1) $display("FAIL bad_valid: got %b want 1", fif.frame_valid); else passed++;
    total++; if (fif.frame_data !== 16'h5078) $display("FAIL bad_data: got %h want 5078", fif.frame_data); else passed++;
    total++; if (fif.frame_err !== 1'b1) $display("FAIL bad_err: got %b want 1", fif.frame_err); else passed++;
    cycles(1);
    pop();
  endtask

  task automatic test_overrun();
    ovr_cnt = 0;
    scan_pats(pats_of(16'h4321), 4, -1);
    scan_pats(pats_of(16'hFEDC), 4, -1);
    cycles(10);
    @(negedge clk);
    total++; if (ovr_cnt !== 1) $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt); else passed++;
    total++; if (fif.frame_valid !== 1'b1) $display("FAIL overrun_valid: got %b want 1", fif.frame_valid); else passed++;
    total++; if (fif.frame_data !== 16'h4321) $display("FAIL overrun_data: got %h want 4321", fif.frame_data); else passed++;
    cycles(1);
    pop();
    @(negedge clk);
    total++; if (fif.frame_valid !== 1'b0) $display("FAIL overrun_drain: got %b want 0", fif.frame_valid); else passed++;
    cycles(1);
  endtask

  task automatic test_stall();
    scan_pats(pats_of(16'h0021), 2, -1);
    cycles(Tmo + 20);
    @(negedge clk);
    total++; if (stall !== 1'b1) $display("FAIL stall_set: got %b want 1", stall); else passed++;
    total++; if (fif.frame_valid !== 1'b0) $display("FAIL stall_noframe: got %b want 0", fif.frame_valid); else passed++;
    cycles(1);
    scan_pats(pats_of(16'h000F), 1, -1);
    @(negedge clk);
    total++; if (stall !== 1'b0) $display("FAIL stall_clear: got %b want 0", stall); else passed++;
    cycles(1);
    scan_pats(pats_of(16'h90AF), 4, -1);
    cycles(10);
    @(negedge clk);
    total++; if (stall !== 1'b0) $display("FAIL stall_after: got %b want 0", stall); else passed++;
    total++; if (fif.frame_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", fif.frame_valid); else passed++;
    total++; if (fif.frame_data !== 16'h90AF) $display("FAIL stall_data: got %h want 90af", fif.frame_data); else passed++;
    cycles(1);
    pop();
  endtask

  task automatic test_reset_mid();
    scan_pats(pats_of(16'h1357), 4, -1);
    scan_pats(pats_of(16'h0024), 2, -1);
    an  = 4'b1011;
    seg = enc(4'h6);
    cycles(2);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (fif.frame_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", fif.frame_valid); else passed++;
    total++; if (fif.frame_data !== 16'h0) $display("FAIL rstmid_data: got %h want 0000", fif.frame_data); else passed++;
    total++; if (fif.frame_err !== 1'b0) $display("FAIL rstmid_err: got %b want 0", fif.frame_err); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rstmid_overrun: got %b want 0", overrun); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", stall); else passed++;
    an  = 4'hF;
    seg = 7'h7F;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    scan_pats(pats_of(16'h9BCD), 4, -1);
    cycles(10);
    @(negedge clk);
    total++; if (fif.frame_valid !== 1'b1) $display("FAIL rstmid_next_valid: got %b want 1", fif.frame_valid); else passed++;
    total++; if (fif.frame_data !== 16'h9BCD) $display("FAIL rstmid_next_data: got %h want 9bcd", fif.frame_data); else passed++;
    total++; if (fif.frame_err !== 1'b0) $display("FAIL rstmid_next_err: got %b want 0", fif.frame_err); else passed++;
  endtask

  initial begin
    fif.frame_ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_bad_pattern();
    test_overrun();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
